// File: rtl/modulation_idx_sampler_if.sv
// Bus between the system-time counter, modulation configuration and the index sampler.
// IDX_UPDATE and its modport entries exist only when MODULATION_SAMPLER_STROBE_EN is defined.
interface modulation_idx_sampler_if;
    logic [63:0] SYS_TIME;
    logic [15:0] CYCLE_M;
    logic [31:0] FREQ_DIV_M;
    logic [15:0] IDX;
`ifdef MODULATION_SAMPLER_STROBE_EN
    logic        IDX_UPDATE;

    modport master (output SYS_TIME, CYCLE_M, FREQ_DIV_M, input IDX, IDX_UPDATE);
    modport slave  (input SYS_TIME, CYCLE_M, FREQ_DIV_M, output IDX, IDX_UPDATE);
`else
    modport master (output SYS_TIME, CYCLE_M, FREQ_DIV_M, input IDX);
    modport slave  (input SYS_TIME, CYCLE_M, FREQ_DIV_M, output IDX);
`endif
endinterface

// File: rtl/modulation_idx_sampler.sv
// IDX = (SYS_TIME / FREQ_DIV_M) mod (CYCLE_M + 1) via two pipelined restoring dividers,
// latency 2*66+1 cycles. MODULATION_SAMPLER_STROBE_EN adds the IDX_UPDATE change strobe.
module modulation_idx_sampler (
    input  logic                     CLK,
    input  logic                     RST,
    modulation_idx_sampler_if.slave  bus
);
    localparam int unsigned DIVIDEND_W    = 64;
    localparam int unsigned DIV_LATENCY   = DIVIDEND_W + 2;
    localparam int unsigned TOTAL_LATENCY = 2 * DIV_LATENCY + 1;

    // Stage A: T / FREQ_DIV_M. Index 0 is the input register, 1..64 the quotient-bit steps.
    logic [63:0] a_num_q [0:DIVIDEND_W];
    logic [63:0] a_num_d [0:DIVIDEND_W];
    logic [31:0] a_rem_q [0:DIVIDEND_W];
    logic [31:0] a_rem_d [0:DIVIDEND_W];
    logic [31:0] a_dvs_q [0:DIVIDEND_W];
    logic [31:0] a_dvs_d [0:DIVIDEND_W];
    logic [63:0] a_quo_q, a_quo_d;
    logic [15:0] cyc_q   [0:DIV_LATENCY-1];
    logic [15:0] cyc_d   [0:DIV_LATENCY-1];
    logic [32:0] a_trial;
    logic        a_ge;

    // Stage B: q mod (CYCLE_M+1); only the remainder is kept, so no quotient bits are shifted in.
    logic [63:0] b_num_q [0:DIVIDEND_W];
    logic [63:0] b_num_d [0:DIVIDEND_W];
    logic [15:0] b_rem_q [0:DIVIDEND_W];
    logic [15:0] b_rem_d [0:DIVIDEND_W];
    logic [16:0] b_dvs_q [0:DIVIDEND_W];
    logic [16:0] b_dvs_d [0:DIVIDEND_W];
    logic [15:0] b_res_q, b_res_d;
    logic [16:0] b_trial;

    logic [15:0] idx_q, idx_d;

    always_comb begin
        a_trial    = '0;
        a_ge       = 1'b0;
        a_num_d[0] = bus.SYS_TIME;
        a_rem_d[0] = '0;
        a_dvs_d[0] = bus.FREQ_DIV_M;
        for (int unsigned i = 0; i < DIVIDEND_W; i++) begin
            // Divisor 0 makes every trial succeed, giving an all-ones quotient.
            a_trial        = {a_rem_q[i], a_num_q[i][63]};
            a_ge           = (a_trial >= {1'b0, a_dvs_q[i]});
            a_num_d[i + 1] = {a_num_q[i][62:0], a_ge};
            a_rem_d[i + 1] = a_ge ? 32'(a_trial - {1'b0, a_dvs_q[i]}) : a_trial[31:0];
            a_dvs_d[i + 1] = a_dvs_q[i];
        end
        a_quo_d = a_num_q[DIVIDEND_W];

        // CYCLE_M travels alongside stage A so it pairs with the same SYS_TIME sample.
        cyc_d[0] = bus.CYCLE_M;
        for (int unsigned i = 1; i < DIV_LATENCY; i++) begin
            cyc_d[i] = cyc_q[i - 1];
        end
    end

    always_comb begin
        b_trial    = '0;
        b_num_d[0] = a_quo_q;
        b_rem_d[0] = '0;
        b_dvs_d[0] = {1'b0, cyc_q[DIV_LATENCY - 1]} + 17'd1;
        for (int unsigned i = 0; i < DIVIDEND_W; i++) begin
            b_trial        = {b_rem_q[i], b_num_q[i][63]};
            b_num_d[i + 1] = {b_num_q[i][62:0], 1'b0};
            b_rem_d[i + 1] = (b_trial >= b_dvs_q[i]) ? 16'(b_trial - b_dvs_q[i]) : b_trial[15:0];
            b_dvs_d[i + 1] = b_dvs_q[i];
        end
        b_res_d = b_rem_q[DIVIDEND_W];
        idx_d   = b_res_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_num_q <= '{default: '0};
            a_rem_q <= '{default: '0};
            a_dvs_q <= '{default: '0};
            a_quo_q <= '0;
            cyc_q   <= '{default: '0};
            b_num_q <= '{default: '0};
            b_rem_q <= '{default: '0};
            b_dvs_q <= '{default: '0};
            b_res_q <= '0;
            idx_q   <= '0;
        end else begin
            a_num_q <= a_num_d;
            a_rem_q <= a_rem_d;
            a_dvs_q <= a_dvs_d;
            a_quo_q <= a_quo_d;
            cyc_q   <= cyc_d;
            b_num_q <= b_num_d;
            b_rem_q <= b_rem_d;
            b_dvs_q <= b_dvs_d;
            b_res_q <= b_res_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.IDX = idx_q;

`ifdef MODULATION_SAMPLER_STROBE_EN
    localparam logic [7:0] WARM_DONE = 8'(TOTAL_LATENCY);

    logic [7:0] warm_q, warm_d;
    logic       upd_q, upd_d;

    // Strobe is held off until the pipeline has flushed its reset contents.
    always_comb begin
        warm_d = (warm_q == WARM_DONE) ? warm_q : warm_q + 8'd1;
        upd_d  = (warm_q == WARM_DONE) && (b_res_q != idx_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            warm_q <= '0;
            upd_q  <= 1'b0;
        end else begin
            warm_q <= warm_d;
            upd_q  <= upd_d;
        end
    end

    assign bus.IDX_UPDATE = upd_q;
`endif
endmodule

// File: tb/tb_modulation_idx_sampler.sv
// Directed bench for modulation_idx_sampler: settled-value vector table plus
// free-running, latency, reset and short-cycle sequences against a sample-history model.
module tb_modulation_idx_sampler;
    logic CLK = 1'b0;
    logic RST;

    modulation_idx_sampler_if bus ();

    modulation_idx_sampler dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] t;
        logic [31:0] f;
        logic [15:0] c;
    } stim_t;

    typedef struct {
        logic [15:0] cyc;
        logic [31:0] fdiv;
        logic [63:0] t;
        logic [15:0] exp_idx;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int unsigned edge_cnt = 0;
    stim_t       hist [256];
    vec_t        vecs [14];
    bit          model_on = 1'b0;
    bit          run_time = 1'b0;
    logic [15:0] exp_cur = '0;
    logic [15:0] exp_prev = '0;
    logic [15:0] last_dut = '0;
    int          mdl_chg = 0;
    int          dut_chg = 0;
    int          pulse_cnt = 0;

    function automatic logic [15:0] ref_idx(input stim_t s);
        logic [63:0] q;
        logic [63:0] m;
        q = (s.f == 32'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : s.t / {32'd0, s.f};
        m = {48'd0, s.c} + 64'd1;
        return 16'(q % m);
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // One clock: record captured stimulus, then compare outputs 1 ns after the edge.
    task automatic step();
        @(posedge CLK);
        if (RST) begin
            edge_cnt = 0;
        end else begin
            edge_cnt++;
            hist[edge_cnt % 256] = '{t: bus.SYS_TIME, f: bus.FREQ_DIV_M, c: bus.CYCLE_M};
        end
        #1;
        exp_prev = exp_cur;
        exp_cur  = (edge_cnt >= 133) ? ref_idx(hist[(edge_cnt - 132) % 256]) : 16'd0;
        if (exp_cur != exp_prev) mdl_chg++;
        if (bus.IDX != last_dut) dut_chg++;
        last_dut = bus.IDX;
        if (model_on) check16("model_idx", bus.IDX, exp_cur);
`ifdef MODULATION_SAMPLER_STROBE_EN
        if (bus.IDX_UPDATE === 1'b1) pulse_cnt++;
        if (model_on)
            check16("idx_update", {15'd0, bus.IDX_UPDATE},
                    {15'd0, (edge_cnt >= 134) && (exp_cur != exp_prev)});
`endif
        if (run_time) bus.SYS_TIME = bus.SYS_TIME + 64'd8;
    endtask

    initial begin
        logic [63:0] s;
        int          run_len;
        bit          first_chg;
        logic [15:0] prev_idx;

        vecs[0]  = '{16'hFFFF, 32'd4096,       64'd0,                  16'h0000};
        vecs[1]  = '{16'hFFFF, 32'd4096,       64'd24575,              16'h0005};
        vecs[2]  = '{16'hFFFF, 32'd4096,       64'h0000_0001_2345_6000, 16'h3456};
        vecs[3]  = '{16'd3,    32'd64,         64'd448,                16'h0003};
        vecs[4]  = '{16'd3,    32'd64,         64'd512,                16'h0000};
        vecs[5]  = '{16'd0,    32'd100,        64'd123456789,          16'h0000};
        vecs[6]  = '{16'd9,    32'd1000,       64'd123456,             16'h0003};
        vecs[7]  = '{16'hFFFF, 32'd1,          64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF};
        vecs[8]  = '{16'hFFFE, 32'd1,          64'd65536,              16'h0001};
        vecs[9]  = '{16'd9,    32'd0,          64'd42,                 16'h0005};
        vecs[10] = '{16'hFFFF, 32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF, 16'h0001};
        vecs[11] = '{16'd6,    32'd3,          64'd1000,               16'h0004};
        vecs[12] = '{16'hFFFF, 32'd4096,       64'h0000_0000_3000_A000, 16'h000A};
        vecs[13] = '{16'd1,    32'd7,          64'd27,                 16'h0001};

        RST            = 1'b1;
        bus.SYS_TIME   = '0;
        bus.CYCLE_M    = 16'hFFFF;
        bus.FREQ_DIV_M = 32'd4096;
        repeat (2) step();
        check16("reset_idx", bus.IDX, 16'h0000);
`ifdef MODULATION_SAMPLER_STROBE_EN
        check16("reset_update", {15'd0, bus.IDX_UPDATE}, 16'h0000);
`endif
        RST      = 1'b0;
        model_on = 1'b1;

        // Settled results: hold each vector beyond the full latency.
        for (int k = 0; k < 14; k++) begin
            bus.CYCLE_M    = vecs[k].cyc;
            bus.FREQ_DIV_M = vecs[k].fdiv;
            bus.SYS_TIME   = vecs[k].t;
            repeat (134) step();
            check16($sformatf("vec%0d", k), bus.IDX, vecs[k].exp_idx);
        end

        // Free-running baseline at fast and nominal rates; change counts must agree.
        bus.CYCLE_M    = 16'hFFFF;
        bus.FREQ_DIV_M = 32'd64;
        bus.SYS_TIME   = 64'h0000_0000_007F_F000;
        run_time       = 1'b1;
        repeat (140) step();
        mdl_chg = 0; dut_chg = 0; pulse_cnt = 0;
        repeat (1000) step();
        check16("chg_count_div64", 16'(dut_chg), 16'(mdl_chg));
`ifdef MODULATION_SAMPLER_STROBE_EN
        check16("pulse_count_div64", 16'(pulse_cnt), 16'(mdl_chg));
`endif
        bus.FREQ_DIV_M = 32'd4096;
        bus.SYS_TIME   = 64'h0000_0123_4567_0000;
        repeat (140) step();
        mdl_chg = 0; dut_chg = 0; pulse_cnt = 0;
        repeat (1600) step();
        check16("chg_count_div4096", 16'(dut_chg), 16'(mdl_chg));
`ifdef MODULATION_SAMPLER_STROBE_EN
        check16("pulse_count_div4096", 16'(pulse_cnt), 16'(mdl_chg));
`endif

        // Latency: divisor step 4096 -> 512 takes effect exactly 133 edges later.
        s = bus.SYS_TIME;
        bus.FREQ_DIV_M = 32'd512;
        repeat (132) step();
        check16("latency_old", bus.IDX, 16'((s - 64'd8) >> 12));
        step();
        check16("latency_new", bus.IDX, 16'(s >> 9));
        repeat (20) step();

        // Asynchronous mid-run reset, then full recovery after the latency.
        #3 RST = 1'b1;
        #1 check16("async_reset", bus.IDX, 16'h0000);
        repeat (3) step();
        #2 RST = 1'b0;
        s = bus.SYS_TIME;
        repeat (132) step();
        check16("reset_flush", bus.IDX, 16'h0000);
        step();
        check16("reset_recover", bus.IDX, 16'(s >> 9));

        // Short cycle: every index held exactly 8 clocks.
        bus.CYCLE_M    = 16'd3;
        bus.FREQ_DIV_M = 32'd64;
        bus.SYS_TIME   = '0;
        repeat (140) step();
        run_len   = 0;
        first_chg = 1'b1;
        prev_idx  = bus.IDX;
        repeat (200) begin
            step();
            run_len++;
            if (bus.IDX != prev_idx) begin
                if (!first_chg) check16("short_hold", 16'(run_len), 16'd8);
                first_chg = 1'b0;
                run_len   = 0;
                prev_idx  = bus.IDX;
            end
        end

        // Degenerate CYCLE_M=0: index pinned at zero.
        bus.CYCLE_M    = 16'd0;
        bus.FREQ_DIV_M = 32'd8;
        repeat (140) step();
        repeat (100) begin
            step();
            check16("degenerate", bus.IDX, 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
